sequence_checker: RTL and testbench

Receive-side companion to `sequence_counter`. It samples a counter value stream and predicts the next value of the modulo sequence, then flags out-of-sequence samples. Lock is acquired and lost by a hunt/sync/locked state machine. It sits at the consumer end of any link carrying counter values, e.g. a count bus crossing into another block, and provides in-system checking that the producer is still stepping correctly.

---
 rtl/sequence_checker.sv | 221 ++++++++++++++++++++++
 tb/tb_sequence_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_checker.sv
// -----------------------------------------------------------------------------
// sequence_checker
//   Receive-side checker for a modulo counter stream. It predicts the next value
//   of the sequence (x+STEP, wrapping after MAX_VAL) and flags out-of-sequence
//   samples. Lock is acquired and lost by a HUNT/SYNC/LOCKED state machine.
//   While LOCKED the prediction free-runs (flywheel), so a single corrupt sample
//   does not re-seed the predictor with bad data.
//
// Optional feature macro: SEQCHK_STICKY_ERR_EN
//   Adds err_clr / err_sticky. err_sticky sets on any err pulse and holds until
//   err_clr is seen at a clock edge; a set in the same cycle wins over the clear.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset, clears all state
//   valid      in   count is sampled this cycle
//   count      in   [WIDTH-1:0] value under test
//   err_clr    in   clears err_sticky (macro only)
//   locked     out  checker is in LOCKED
//   err        out  one-cycle pulse per mismatching sample while LOCKED
//   err_count  out  [ERR_W-1:0] saturating count of mismatches while LOCKED
//   expected   out  [WIDTH-1:0] value the next valid sample must equal
//   state      out  [1:0] HUNT=0, SYNC=1, LOCKED=2
//   err_sticky out  sticky error flag (macro only)
// All outputs are registered.
// -----------------------------------------------------------------------------
module sequence_checker #(
    parameter int WIDTH      = 4,
    parameter int STEP       = 1,
    parameter int MAX_VAL    = 15,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] count,
`ifdef SEQCHK_STICKY_ERR_EN
    input  logic             err_clr,
    output logic             err_sticky,
`endif
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [WIDTH:0]   STEP_EXT   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MAX_EXT    = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   ONE_EXT    = (WIDTH+1)'(1'b1);
    localparam logic [RUN_W-1:0] LOCK_RUN   = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1'b1);
    localparam logic [RUN_W-1:0] RUN_ZERO   = RUN_W'(1'b0);
    localparam logic [MISS_W-1:0] UNLOCK_MISS = MISS_W'(UNLOCK_CNT);
    localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1'b1);
    localparam logic [MISS_W-1:0] MISS_ZERO = MISS_W'(1'b0);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1'b1);

    // Successor in the modulo sequence; the sum is one bit wider so it cannot
    // silently overflow before the wrap comparison.
    function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] sum;
        logic [WIDTH:0] wrapped;
        sum     = {1'b0, x} + STEP_EXT;
        wrapped = sum - MAX_EXT - ONE_EXT;
        if (sum <= MAX_EXT) begin
            next_val = sum[WIDTH-1:0];
        end else begin
            next_val = wrapped[WIDTH-1:0];
        end
    endfunction

    state_t              state_r, state_s;
    logic [WIDTH-1:0]    expected_r, expected_s;
    logic [RUN_W-1:0]    run_r, run_s;
    logic [MISS_W-1:0]   miss_r, miss_s;
    logic [ERR_W-1:0]    err_count_r, err_count_s;
    logic                err_r, err_s;
    logic                locked_r;
    logic                in_range_s;
    logic                match_s;

    // Next-state, predictor and error bookkeeping for one sample.
    always_comb begin
        state_s     = state_r;
        expected_s  = expected_r;
        run_s       = run_r;
        miss_s      = miss_r;
        err_count_s = err_count_r;
        err_s       = 1'b0;
        in_range_s  = ({1'b0, count} <= MAX_EXT);
        match_s     = in_range_s && (count == expected_r);

        if (valid) begin
            case (state_r)
                HUNT: begin
                    // An out-of-range value cannot seed the predictor.
                    if (in_range_s) begin
                        expected_s = next_val(count);
                        run_s      = RUN_ONE;
                        miss_s     = MISS_ZERO;
                        if (LOCK_CNT == 1) begin
                            state_s = LOCKED;
                        end else begin
                            state_s = SYNC;
                        end
                    end else begin
                        state_s = HUNT;
                    end
                end
                SYNC: begin
                    if (match_s) begin
                        expected_s = next_val(expected_r);
                        run_s      = run_r + RUN_ONE;
                        if (run_s == LOCK_RUN) begin
                            state_s = LOCKED;
                            miss_s  = MISS_ZERO;
                        end else begin
                            state_s = SYNC;
                        end
                    end else if (!in_range_s) begin
                        state_s = HUNT;
                        run_s   = RUN_ZERO;
                    end else begin
                        expected_s = next_val(count);
                        run_s      = RUN_ONE;
                        state_s    = SYNC;
                    end
                end
                LOCKED: begin
                    // Flywheel: advance on the prediction, never on the sample.
                    expected_s = next_val(expected_r);
                    if (match_s) begin
                        miss_s = MISS_ZERO;
                    end else begin
                        err_s = 1'b1;
                        if (err_count_r != ERR_MAX) begin
                            err_count_s = err_count_r + ERR_ONE;
                        end else begin
                            err_count_s = err_count_r;
                        end
                        miss_s = miss_r + MISS_ONE;
                        if (miss_s == UNLOCK_MISS) begin
                            state_s = HUNT;
                            run_s   = RUN_ZERO;
                            miss_s  = MISS_ZERO;
                        end else begin
                            state_s = LOCKED;
                        end
                    end
                end
                default: begin
                    state_s = HUNT;
                    run_s   = RUN_ZERO;
                    miss_s  = MISS_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= HUNT;
            expected_r  <= {WIDTH{1'b0}};
            run_r       <= RUN_ZERO;
            miss_r      <= MISS_ZERO;
            err_count_r <= {ERR_W{1'b0}};
            err_r       <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            expected_r  <= expected_s;
            run_r       <= run_s;
            miss_r      <= miss_s;
            err_count_r <= err_count_s;
            err_r       <= err_s;
            locked_r    <= (state_s == LOCKED);
        end
    end

`ifdef SEQCHK_STICKY_ERR_EN
    logic err_sticky_r;

    // Sticky error flag; a new error in the clear cycle keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky_r <= 1'b0;
        end else if (err_s) begin
            err_sticky_r <= 1'b1;
        end else if (err_clr) begin
            err_sticky_r <= 1'b0;
        end else begin
            err_sticky_r <= err_sticky_r;
        end
    end

    assign err_sticky = err_sticky_r;
`endif

    assign state     = state_r;
    assign locked    = locked_r;
    assign err       = err_r;
    assign err_count = err_count_r;
    assign expected  = expected_r;

endmodule

// File: tb/tb_sequence_checker.sv
// -----------------------------------------------------------------------------
// tb_sequence_checker
//   Directed bench for sequence_checker. Three instances:
//     dut_a  default parameters
//     dut_b  STEP=3, MAX_VAL=9 (gaps, wrap, out-of-range samples)
//     dut_c  ERR_W=2, UNLOCK_CNT=8 (error counter saturation)
//   Inputs change 1 time unit after the rising edge; outputs are sampled then.
// -----------------------------------------------------------------------------
module tb_sequence_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
    logic [3:0] count_a = 4'd0, count_b = 4'd0, count_c = 4'd0;
    logic       err_clr_a = 1'b0;
    logic       err_clr_off = 1'b0;

    logic       locked_a, err_a, locked_b, err_b, locked_c, err_c;
    logic [7:0] err_count_a, err_count_b;
    logic [1:0] err_count_c;
    logic [3:0] expected_a, expected_b, expected_c;
    logic [1:0] state_a, state_b, state_c;
    logic       sticky_a, sticky_b, sticky_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifndef SEQCHK_STICKY_ERR_EN
    assign sticky_a = 1'b0;
    assign sticky_b = 1'b0;
    assign sticky_c = 1'b0;
`endif

    sequence_checker dut_a (
        .clk(clk), .reset(reset), .valid(valid_a), .count(count_a),
`ifdef SEQCHK_STICKY_ERR_EN
        .err_clr(err_clr_a), .err_sticky(sticky_a),
`endif
        .locked(locked_a), .err(err_a), .err_count(err_count_a),
        .expected(expected_a), .state(state_a)
    );

    sequence_checker #(.STEP(3), .MAX_VAL(9)) dut_b (
        .clk(clk), .reset(reset), .valid(valid_b), .count(count_b),
`ifdef SEQCHK_STICKY_ERR_EN
        .err_clr(err_clr_off), .err_sticky(sticky_b),
`endif
        .locked(locked_b), .err(err_b), .err_count(err_count_b),
        .expected(expected_b), .state(state_b)
    );

    sequence_checker #(.ERR_W(2), .UNLOCK_CNT(8)) dut_c (
        .clk(clk), .reset(reset), .valid(valid_c), .count(count_c),
`ifdef SEQCHK_STICKY_ERR_EN
        .err_clr(err_clr_off), .err_sticky(sticky_c),
`endif
        .locked(locked_c), .err(err_c), .err_count(err_count_c),
        .expected(expected_c), .state(state_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [3:0] c);
        valid_a = v; count_a = c; tick();
    endtask

    task automatic drive_b(input logic v, input logic [3:0] c);
        valid_b = v; count_b = c; tick();
    endtask

    task automatic drive_c(input logic v, input logic [3:0] c);
        valid_c = v; count_c = c; tick();
    endtask

    task automatic do_reset();
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_a(input string tag, input int st, input int lk, input int er,
                           input int ec, input int ex);
        check_eq({tag, ".state"},     32'(state_a),     32'(st));
        check_eq({tag, ".locked"},    32'(locked_a),    32'(lk));
        check_eq({tag, ".err"},       32'(err_a),       32'(er));
        check_eq({tag, ".err_count"}, 32'(err_count_a), 32'(ec));
        check_eq({tag, ".expected"},  32'(expected_a),  32'(ex));
    endtask

    initial begin
        #1;
        // Reset values
        check_a("rst0", 0, 0, 0, 0, 0);
        check_eq("rst0.sticky", 32'(sticky_a), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Acquire lock: 5,6,7,8
        drive_a(1'b1, 4'd5); check_a("lock5", 1, 0, 0, 0, 6);
        drive_a(1'b1, 4'd6); check_a("lock6", 1, 0, 0, 0, 7);
        drive_a(1'b1, 4'd7); check_a("lock7", 2, 1, 0, 0, 8);
        drive_a(1'b1, 4'd8); check_a("lock8", 2, 1, 0, 0, 9);

        // Walk up to the wrap, then 14,15,0,1
        for (int v = 9; v <= 15; v++) begin
            drive_a(1'b1, 4'(v));
            check_eq("walk.err", 32'(err_a), 32'd0);
        end
        drive_a(1'b1, 4'd0); check_a("wrap0", 2, 1, 0, 0, 1);
        drive_a(1'b1, 4'd1); check_a("wrap1", 2, 1, 0, 0, 2);

        // Single glitch: 2,3,4,9,(idle),6,7
        drive_a(1'b1, 4'd2);
        drive_a(1'b1, 4'd3); check_a("gl3", 2, 1, 0, 0, 4);
        drive_a(1'b1, 4'd4); check_a("gl4", 2, 1, 0, 0, 5);
        drive_a(1'b1, 4'd9); check_a("gl9", 2, 1, 1, 1, 6);
        check_eq("gl9.sticky", 32'(sticky_a), `ifdef SEQCHK_STICKY_ERR_EN 32'd1 `else 32'd0 `endif);
        drive_a(1'b0, 4'd0); check_a("glidle", 2, 1, 0, 1, 6);
        drive_a(1'b1, 4'd6); check_a("gl6", 2, 1, 0, 1, 7);
        check_eq("gl6.sticky", 32'(sticky_a), `ifdef SEQCHK_STICKY_ERR_EN 32'd1 `else 32'd0 `endif);
        drive_a(1'b1, 4'd7); check_a("gl7", 2, 1, 0, 1, 8);

`ifdef SEQCHK_STICKY_ERR_EN
        // Sticky clear
        err_clr_a = 1'b1;
        drive_a(1'b0, 4'd0);
        err_clr_a = 1'b0;
        check_eq("clr.sticky", 32'(sticky_a), 32'd0);
        // Error and clear in the same cycle: set wins
        err_clr_a = 1'b1;
        drive_a(1'b1, 4'd0);
        err_clr_a = 1'b0;
        check_eq("setwins.sticky", 32'(sticky_a), 32'd1);
        check_a("setwins", 2, 1, 1, 2, 9);
        drive_a(1'b1, 4'd9);
        check_eq("setwins2.sticky", 32'(sticky_a), 32'd1);
`endif

        // Asynchronous reset while LOCKED: outputs go to reset values at once
        reset = 1'b1;
        #1;
        check_a("arst", 0, 0, 0, 0, 0);
        check_eq("arst.sticky", 32'(sticky_a), 32'd0);
        tick();
        reset = 1'b0;

        // Post-reset seed, SYNC re-seed, lock at expected=4
        drive_a(1'b1, 4'd9); check_a("s9", 1, 0, 0, 0, 10);
        drive_a(1'b1, 4'd1); check_a("s1", 1, 0, 0, 0, 2);
        drive_a(1'b1, 4'd2); check_a("s2", 1, 0, 0, 0, 3);
        drive_a(1'b1, 4'd3); check_a("s3", 2, 1, 0, 0, 4);

        // Unlock with 10,11 then relock with 12,13,14
        drive_a(1'b1, 4'd10); check_a("u10", 2, 1, 1, 1, 5);
        drive_a(1'b1, 4'd11); check_a("u11", 0, 0, 1, 2, 6);
        drive_a(1'b1, 4'd12); check_a("r12", 1, 0, 0, 2, 13);
        drive_a(1'b1, 4'd13); check_a("r13", 1, 0, 0, 2, 14);
        drive_a(1'b1, 4'd14); check_a("r14", 2, 1, 0, 2, 15);
        drive_a(1'b0, 4'd0);

        // STEP=3, MAX_VAL=9 with idle gaps: 2,5,8,1,4
        do_reset();
        drive_b(1'b1, 4'd2);
        check_eq("b2.state", 32'(state_b), 32'd1);
        check_eq("b2.exp",   32'(expected_b), 32'd5);
        drive_b(1'b0, 4'd7);
        check_eq("bidle.state", 32'(state_b), 32'd1);
        check_eq("bidle.exp",   32'(expected_b), 32'd5);
        drive_b(1'b1, 4'd5);
        check_eq("b5.exp", 32'(expected_b), 32'd8);
        drive_b(1'b0, 4'd0);
        drive_b(1'b1, 4'd8);
        check_eq("b8.locked", 32'(locked_b), 32'd1);
        check_eq("b8.exp",    32'(expected_b), 32'd1);
        drive_b(1'b0, 4'd3);
        check_eq("bidle2.locked", 32'(locked_b), 32'd1);
        check_eq("bidle2.exp",    32'(expected_b), 32'd1);
        drive_b(1'b1, 4'd1);
        check_eq("b1.err", 32'(err_b), 32'd0);
        check_eq("b1.exp", 32'(expected_b), 32'd4);
        drive_b(1'b0, 4'd0);
        drive_b(1'b1, 4'd4);
        check_eq("b4.err", 32'(err_b), 32'd0);
        check_eq("b4.exp", 32'(expected_b), 32'd7);
        // Out-of-range while LOCKED is a mismatch; flywheel 7 -> 0
        drive_b(1'b1, 4'd12);
        check_eq("b12.err",  32'(err_b), 32'd1);
        check_eq("b12.ecnt", 32'(err_count_b), 32'd1);
        check_eq("b12.lock", 32'(locked_b), 32'd1);
        check_eq("b12.exp",  32'(expected_b), 32'd0);
        drive_b(1'b1, 4'd0);
        check_eq("b0.err", 32'(err_b), 32'd0);
        check_eq("b0.exp", 32'(expected_b), 32'd3);
        // Out-of-range in SYNC returns to HUNT
        do_reset();
        drive_b(1'b1, 4'd2);
        drive_b(1'b1, 4'd13);
        check_eq("bsync.state", 32'(state_b), 32'd0);
        check_eq("bsync.err",   32'(err_b), 32'd0);
        drive_b(1'b0, 4'd0);

        // Saturation: ERR_W=2, UNLOCK_CNT=8
        do_reset();
        drive_c(1'b1, 4'd0);
        drive_c(1'b1, 4'd1);
        drive_c(1'b1, 4'd2);
        check_eq("c.locked", 32'(locked_c), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            drive_c(1'b1, 4'd9);
            check_eq("csat.err",  32'(err_c), 32'd1);
            check_eq("csat.ecnt", 32'(err_count_c), 32'((i > 3) ? 3 : i));
            check_eq("csat.exp",  32'(expected_c), 32'(3 + i));
        end
        check_eq("csat.locked", 32'(locked_c), 32'd1);
        check_eq("csat.state",  32'(state_c), 32'd2);
        drive_c(1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
